// File: rtl/conv_pkg.sv
// Shared types, defaults and arithmetic helpers for the streaming 3x3 conv layer.
package conv_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned WW_DEF = 8;
  localparam int unsigned BW_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_FLUSH,
    ST_DRAIN
  } state_t;

  // Accumulator width: full product sum over all taps plus bias, with one guard bit.
  function automatic int unsigned acc_w(input int unsigned dw, input int unsigned ww,
                                        input int unsigned bw, input int unsigned taps);
    int unsigned p;
    p = dw + 1 + ww + $clog2(taps);
    return ((p > bw) ? p : bw) + 1;
  endfunction

  // ReLU, arithmetic shift, then clamp to the largest positive DW-bit signed value.
  function automatic logic [31:0] sat_relu_shift(input logic signed [63:0] acc,
                                                 input int unsigned shift,
                                                 input int unsigned dw);
    logic signed [63:0] s;
    logic signed [63:0] lim;
    if (acc < 0) return '0;
    s   = acc >>> shift;
    lim = (64'sd1 <<< (dw - 1)) - 64'sd1;
    if (s > lim) s = lim;
    return s[31:0];
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Two row delay lines plus the 3x3 window; advances one pixel per enabled cycle.
module conv_line_buffer #(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned PW    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [PW-1:0]   din,
  output logic [9*PW-1:0] win
);

  logic [PW-1:0] row1 [IMG_W];
  logic [PW-1:0] row2 [IMG_W];
  logic [PW-1:0] tap  [9];

  // Shift the delay lines and slide the window left; tap index = ky*3 + kx.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < IMG_W; i++) begin
        row1[i] <= '0;
        row2[i] <= '0;
      end
      for (int t = 0; t < 9; t++) tap[t] <= '0;
    end else if (en) begin
      row1[0] <= din;
      row2[0] <= row1[IMG_W-1];
      for (int i = 1; i < IMG_W; i++) begin
        row1[i] <= row1[i-1];
        row2[i] <= row2[i-1];
      end
      for (int ky = 0; ky < 3; ky++) begin
        tap[ky*3+0] <= tap[ky*3+1];
        tap[ky*3+1] <= tap[ky*3+2];
      end
      tap[2] <= row2[IMG_W-1];
      tap[5] <= row1[IMG_W-1];
      tap[8] <= din;
    end
  end

  // Flatten the window for the MAC array.
  always_comb begin
    win = '0;
    for (int t = 0; t < 9; t++) win[t*PW +: PW] = tap[t];
  end

endmodule

// File: rtl/conv2d_stream_mc.sv
// Streaming 3x3 conv (stride 1, zero pad 1) with self-flush, backpressure and runtime weights.
module conv2d_stream_mc
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W       = 28,
  parameter int unsigned IMG_H       = 28,
  parameter int unsigned CH_IN       = 1,
  parameter int unsigned CH_OUT      = 8,
  parameter int unsigned DW          = DW_DEF,
  parameter int unsigned WW          = WW_DEF,
  parameter int unsigned BW          = BW_DEF,
  parameter int unsigned QUANT_SHIFT = 0
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    cfg_we,
  input  logic [$clog2(CH_OUT*CH_IN*9+CH_OUT)-1:0] cfg_addr,
  input  logic [BW-1:0]                           cfg_data,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [CH_IN*DW-1:0]                     in_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [CH_OUT*DW-1:0]                    out_data,
  output logic                                    busy,
  output logic                                    frame_done
);

  localparam int unsigned NW    = CH_OUT*CH_IN*9;
  localparam int unsigned AW    = $clog2(NW+CH_OUT);
  localparam int unsigned PW    = CH_IN*DW;
  localparam int unsigned NPIX  = IMG_W*IMG_H;
  localparam int unsigned ACC_W = acc_w(DW, WW, BW, CH_IN*9);
  localparam int unsigned PCW   = $clog2(NPIX+IMG_W+2);
  localparam int unsigned OCW   = $clog2(NPIX+1);
  localparam int unsigned RW    = $clog2(IMG_H+1);
  localparam int unsigned CW    = $clog2(IMG_W+1);

  state_t                  state, state_nx;
  logic                    stall, accept, inject, push, trig, out_hs;
  logic [PW-1:0]           pix;
  logic [PCW-1:0]          push_cnt;
  logic [OCW-1:0]          out_cnt;
  logic [RW-1:0]           orow;
  logic [CW-1:0]           ocol;
  logic [9*PW-1:0]         win;
  logic                    v0, v1;
  logic                    m_top, m_bot, m_left, m_right;
  logic signed [WW-1:0]    wmem [NW];
  logic signed [BW-1:0]    bmem [CH_OUT];
  logic signed [ACC_W-1:0] acc_c [CH_OUT];
  logic signed [ACC_W-1:0] acc1  [CH_OUT];
  logic [CH_OUT*DW-1:0]    post_c;

  assign stall      = out_valid && !out_ready;
  assign in_ready   = ((state == ST_IDLE) || (state == ST_FILL) || (state == ST_RUN)) && !stall;
  assign accept     = in_valid && in_ready;
  assign inject     = (state == ST_FLUSH) && !stall;
  assign push       = accept || inject;
  assign pix        = inject ? '0 : in_data;
  // Pushes beyond the first IMG_W+1 each complete the window of one output pixel.
  assign trig       = push && (push_cnt > PCW'(IMG_W));
  assign out_hs     = out_valid && out_ready;
  assign frame_done = out_hs && (out_cnt == OCW'(NPIX-1));
  assign busy       = (state != ST_IDLE);

  conv_line_buffer #(.IMG_W(IMG_W), .PW(PW)) u_lb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (push),
    .din   (pix),
    .win   (win)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic driven by push/output counts.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_FILL;
      ST_FILL:  if (accept && push_cnt == PCW'(IMG_W)) state_nx = ST_RUN;
      ST_RUN:   if (accept && push_cnt == PCW'(NPIX-1)) state_nx = ST_FLUSH;
      ST_FLUSH: if (inject && push_cnt == PCW'(NPIX+IMG_W)) state_nx = ST_DRAIN;
      ST_DRAIN: if (frame_done) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Push/output counters and raster position of the output being assembled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      push_cnt <= '0;
      out_cnt  <= '0;
      orow     <= '0;
      ocol     <= '0;
    end else begin
      if (frame_done) begin
        push_cnt <= '0;
        out_cnt  <= '0;
      end else begin
        if (push)   push_cnt <= push_cnt + PCW'(1);
        if (out_hs) out_cnt  <= out_cnt + OCW'(1);
      end
      if (trig) begin
        if (ocol == CW'(IMG_W-1)) begin
          ocol <= '0;
          orow <= (orow == RW'(IMG_H-1)) ? '0 : orow + RW'(1);
        end else begin
          ocol <= ocol + CW'(1);
        end
      end
    end
  end

  // Weight/bias RAM; only written while idle so a running frame sees stable coefficients.
  always_ff @(posedge clk) begin
    if (rst_n && cfg_we && state == ST_IDLE) begin
      for (int i = 0; i < NW; i++)
        if (cfg_addr == AW'(i)) wmem[i] <= cfg_data[WW-1:0];
      for (int i = 0; i < CH_OUT; i++)
        if (cfg_addr == AW'(NW+i)) bmem[i] <= cfg_data;
    end
  end

  // MAC array over the masked window: border taps outside the frame contribute zero.
  always_comb begin
    for (int co = 0; co < CH_OUT; co++) begin
      acc_c[co] = ACC_W'(bmem[co]);
      for (int ci = 0; ci < CH_IN; ci++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            if (!((ky == 0 && m_top) || (ky == 2 && m_bot) ||
                  (kx == 0 && m_left) || (kx == 2 && m_right)))
              acc_c[co] = acc_c[co] +
                ACC_W'($signed({1'b0, win[(ky*3+kx)*PW + ci*DW +: DW]})) *
                ACC_W'(wmem[(co*CH_IN+ci)*9 + ky*3 + kx]);
    end
  end

  // ReLU, shift and clamp per output channel.
  always_comb begin
    post_c = '0;
    for (int co = 0; co < CH_OUT; co++)
      post_c[co*DW +: DW] = DW'(sat_relu_shift(64'(acc1[co]), QUANT_SHIFT, DW));
  end

  // Window-valid, MAC and output stages; the whole pipeline freezes on output stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      m_top     <= 1'b0;
      m_bot     <= 1'b0;
      m_left    <= 1'b0;
      m_right   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int co = 0; co < CH_OUT; co++) acc1[co] <= '0;
    end else if (!stall) begin
      v0 <= trig;
      if (trig) begin
        m_top   <= (orow == '0);
        m_bot   <= (orow == RW'(IMG_H-1));
        m_left  <= (ocol == '0);
        m_right <= (ocol == CW'(IMG_W-1));
      end
      v1 <= v0;
      if (v0) for (int co = 0; co < CH_OUT; co++) acc1[co] <= acc_c[co];
      out_valid <= v1;
      if (v1) out_data <= post_c;
    end
  end

endmodule
